// File: rtl/uart_pkg.sv
// Shared UART TX definitions: line-select encodings, controller states, default width.
// The serializer's line mux decodes the same MUX_* values.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic [2:0] MUX_IDLE   = 3'd0;
    localparam logic [2:0] MUX_START  = 3'd1;
    localparam logic [2:0] MUX_DATA   = 3'd2;
    localparam logic [2:0] MUX_PARITY = 3'd3;
    localparam logic [2:0] MUX_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // ALIGN idles the line: the frame has not started until the first full tick interval.
    function automatic logic [2:0] state_to_mux(input tx_state_t s);
        logic [2:0] sel;
        sel = MUX_IDLE;
        case (s)
            START:   sel = MUX_START;
            DATA:    sel = MUX_DATA;
            PARITY:  sel = MUX_PARITY;
            STOP:    sel = MUX_STOP;
            default: sel = MUX_IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: latches a byte on accept, then steps start/data/parity/stop on baud_tick.
// All outputs registered; mux_sel lags the state by one UCLK; tx_ready is low for the whole frame.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = UART_DATA_WIDTH,
    localparam int FRAME_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  stop2,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  ser_en,
    output logic [FRAME_W-1:0]    frame,
    output logic [2:0]            mux_sel,
    output logic                  parity_bit,
    output logic                  busy,
    output logic                  tx_done
);

    tx_state_t state, state_nxt;

    logic                  par_en_q, stop2_q, stop_cnt;
    logic                  accept, last_data, stop_last;

    logic                  tx_ready_d, busy_d, tx_done_d, ser_en_d, parity_d;
    logic                  par_en_d, stop2_d, stop_cnt_d;
    logic [FRAME_W-1:0]    frame_d;
    logic [2:0]            mux_sel_d;
    logic [DATA_WIDTH-1:0] data_d;

    assign accept    = tx_valid && tx_ready;
    assign last_data = (frame == FRAME_W'(DATA_WIDTH - 1));
    assign stop_last = !stop2_q || stop_cnt;

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ALIGN;
            ALIGN:   if (baud_tick) state_nxt = START;
            START:   if (baud_tick) state_nxt = DATA;
            DATA:    if (baud_tick && last_data) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (baud_tick) state_nxt = STOP;
            STOP:    if (baud_tick && stop_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_ready_d = (state_nxt == IDLE);
        busy_d     = (state_nxt != IDLE);
        tx_done_d  = (state == STOP) && baud_tick && stop_last;
        ser_en_d   = baud_tick && ((state == START) || ((state == DATA) && !last_data));
        mux_sel_d  = state_to_mux(state);

        frame_d = frame;
        if (baud_tick && (state == START))
            frame_d = '0;
        else if (baud_tick && (state == DATA) && !last_data)
            frame_d = frame + FRAME_W'(1);

        // Second stop bit is counted by a single flag that is cleared outside STOP.
        stop_cnt_d = (state == STOP) ? (stop_cnt | baud_tick) : 1'b0;

        data_d   = parallel_data;
        parity_d = parity_bit;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        if (accept) begin
            data_d   = tx_data;
            parity_d = (^tx_data) ^ par_odd;
            par_en_d = par_en;
            stop2_d  = stop2;
        end
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            tx_ready      <= 1'b1;
            busy          <= 1'b0;
            tx_done       <= 1'b0;
            ser_en        <= 1'b0;
            frame         <= '0;
            mux_sel       <= MUX_IDLE;
            parallel_data <= '0;
            parity_bit    <= 1'b0;
            par_en_q      <= 1'b0;
            stop2_q       <= 1'b0;
            stop_cnt      <= 1'b0;
        end else begin
            tx_ready      <= tx_ready_d;
            busy          <= busy_d;
            tx_done       <= tx_done_d;
            ser_en        <= ser_en_d;
            frame         <= frame_d;
            mux_sel       <= mux_sel_d;
            parallel_data <= data_d;
            parity_bit    <= parity_d;
            par_en_q      <= par_en_d;
            stop2_q       <= stop2_d;
            stop_cnt      <= stop_cnt_d;
        end
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side sequencer that sits directly upstream of the UART TX bit serializer.
- Accepts one parallel byte per frame over a valid/ready handshake and holds it stable as the serializer's parallel input.
- Steps a frame-bit index and ser_en strobe, timed by the baud tick.
- Drives the line-mux select (idle/start/data/parity/stop) plus the computed parity bit, so the TX line can be assembled downstream.

Parameters:
- DATA_WIDTH, 8, data bits per frame; also sets the width of parallel_data and frame.
- FRAME_W, $clog2(DATA_WIDTH), width of the frame index (derived; not to be overridden).

Ports:
- UCLK  in  1  UART clock.
- reset  in  1  asynchronous reset, active-high.
- baud_tick  in  1  one-UCLK pulse marking each bit-period boundary.
- tx_data  in  DATA_WIDTH  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a byte.
- par_en  in  1  parity bit enabled; sampled at accept.
- par_odd  in  1  1 = odd parity, 0 = even; sampled at accept.
- stop2  in  1  1 = two stop bits, 0 = one; sampled at accept.
- parallel_data  out  DATA_WIDTH  latched byte, to the serializer.
- ser_en  out  1  serializer load strobe.
- frame  out  FRAME_W  data-bit index, to the serializer.
- mux_sel  out  3  line select: 0 IDLE(1), 1 START(0), 2 DATA(serializer output), 3 PARITY, 4 STOP(1).
- parity_bit  out  1  parity value for the PARITY slot.
- busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at end of the last stop bit.

Behaviour:
Reset
- Asynchronous, active-high; takes effect immediately.
- Reset values: state IDLE, tx_ready=1, parallel_data=0, ser_en=0, frame=0, mux_sel=0, parity_bit=0, busy=0, tx_done=0.
- Reset mid-frame aborts the frame; the byte is lost; mux_sel returns to IDLE immediately.

State machine, all outputs registered:
- IDLE: tx_ready=1.
  - On tx_valid && tx_ready: latch tx_data into parallel_data; latch par_en, par_odd, stop2.
  - parity_bit = (^tx_data) ^ par_odd.
  - Go to ALIGN; busy=1.
- ALIGN: wait for baud_tick, then go to START. A baud_tick in the same cycle as accept is ignored, so every bit lasts exactly one full tick interval.
- START: on baud_tick, go to DATA with frame=0 and pulse ser_en for one cycle.
- DATA: on baud_tick:
  - If frame < DATA_WIDTH-1: frame+1 and pulse ser_en.
  - Else: go to PARITY if par_en, otherwise STOP.
- PARITY: on baud_tick, go to STOP.
- STOP: one tick interval, or two if stop2 (one-bit sub-counter). On the final tick: go to IDLE, pulse tx_done, busy=0, tx_ready=1 in the following cycle.

Timing and alignment
- mux_sel tracks the state delayed by exactly one UCLK. This matches the serializer's one-cycle register latency, so every slot (not just data) is shifted uniformly.
- ALIGN maps to mux_sel IDLE.
- ser_en asserts only in the first cycle of each DATA bit; exactly DATA_WIDTH pulses per frame.

Boundary conditions
- frame never exceeds DATA_WIDTH-1 and holds its value outside DATA.
- parallel_data is stable from accept until the next accept.
- tx_valid while busy is ignored (tx_ready=0); tx_data changes during a frame have no effect.
- Back-to-back: a byte offered in the first IDLE cycle after tx_done is accepted there; its start bit begins at the next baud_tick.
- Config inputs changing mid-frame have no effect.
- baud_tick held high continuously: advance one state per cycle (legal, used for fast test).

Decomposition:
- Shared package uart_pkg holds:
  - the line-select encodings MUX_IDLE/START/DATA/PARITY/STOP;
  - the state enum (IDLE, ALIGN, START, DATA, PARITY, STOP);
  - the DATA_WIDTH default.
- The serializer consumes the same MUX encodings at the line mux.
- No sub-module required. An optional uart_baud_gen (baud_tick source) sits beside this block and is out of scope here.

Test Plan:
- Reset, then 0xA5, par_en=1, par_odd=0, stop2=0, tick every 16 cycles:
  - frame 0..7, 8 ser_en pulses;
  - parity_bit=0;
  - mux_sel 1,2×8,3,4,0;
  - tx_done once, 11 tick intervals after ALIGN.
- 0x01, par_en=1, par_odd=1: parity_bit=0. Same byte with par_odd=0: parity_bit=1.
- 0x3C, par_en=0, stop2=1: no PARITY slot; STOP lasts 2 tick intervals; tx_done after the 2nd.
- Accept in the same cycle as baud_tick: START begins at the following tick, not this one.
- tx_valid held with 0x11 then 0x22 back-to-back:
  - 0x22 accepted in the first IDLE cycle after tx_done;
  - a 0x33 driven on tx_data mid-frame is never latched.
- Assert reset during DATA at frame=4: all outputs return to reset values immediately; no tx_done; the next byte transmits normally.
